// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_e        : loader FSM states. The state after the last write is
//                    ST_CHK when PROG_LOADER_CHECKSUM_EN is defined and
//                    ST_FIN otherwise. ST_TAIL names it in either build.
//   HDR_BYTES      : header length in bytes (ADR_H, ADR_L, CNT_H, CNT_L).
//   BYTES_PER_WORD : payload bytes per instruction word.
//   DEF_ADDR_W     : default instruction-memory address width.
package prog_loader_pkg;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEF_ADDR_W     = 11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_AH,
    ST_HDR_AL,
    ST_HDR_CH,
    ST_HDR_CL,
    ST_DATA,
    ST_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK,
`else
    ST_FIN,
`endif
    ST_DONE,
    ST_ERR
  } state_e;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CHK;
`else
  localparam state_e ST_TAIL = ST_FIN;
`endif

endpackage

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: packs bytes MSB-first into a DATA_W word.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   clear_i      : restart assembly (start of a new load)
//   byte_en_i    : byte_i is consumed this cycle
//   byte_i       : payload byte
//   word_o       : assembled word (holds its value between bytes)
//   word_valid_o : high in the cycle the last byte of a word is consumed
module prog_loader_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_en_i) begin
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[DATA_W-9:0], byte_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_en_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the CPU instruction memory.
// Stream: ADR_H ADR_L CNT_H CNT_L, then CNT words of 4 bytes MSB first.
// Optional trailing XOR checksum byte with PROG_LOADER_CHECKSUM_EN.
//   clk, resetn        : clock (rising edge), async active-low reset
//   start              : one-cycle pulse; begins a load from IDLE/DONE/ERR
//   byte_in/byte_valid : stream byte and its valid
//   byte_ready         : loader accepts a byte this cycle
//   w_instruction      : word to instruction memory
//   w_enable           : one-cycle write strobe
//   w_adrs             : write address (wraps modulo 2^ADDR_W)
//   cpu_en             : CPU run enable (AUTO_RUN after a good load)
//   busy, done, err    : load in progress / last load OK / last load aborted
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = 32,
  parameter bit          AUTO_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_CNT = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [7:0]        adr_h_q, adr_h_d;
  logic [7:0]        cnt_h_q, cnt_h_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              idle_like;
  logic              start_ok;
  logic              asm_en;
  logic              word_valid;
  logic [15:0]       count;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign start_ok  = start && idle_like;
  assign count     = {cnt_h_q, byte_in};

  // Ready is a pure state decode so the assembler's word_valid never loops
  // back into it through the next-state logic.
`ifdef PROG_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q inside {ST_HDR_AH, ST_HDR_AL, ST_HDR_CH, ST_HDR_CL,
                                       ST_DATA, ST_CHK});
`else
  assign byte_ready = (state_q inside {ST_HDR_AH, ST_HDR_AL, ST_HDR_CH, ST_HDR_CL,
                                       ST_DATA});
`endif

  assign asm_en = byte_valid && (state_q == ST_DATA);

  prog_loader_word_assembler #(
    .DATA_W (DATA_W)
  ) u_word_assembler (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .clear_i      (start_ok),
    .byte_en_i    (asm_en),
    .byte_i       (byte_in),
    .word_o       (w_instruction),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    adr_h_d = adr_h_q;
    cnt_h_d = cnt_h_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR_AH;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_HDR_AH: begin
        if (byte_valid) begin
          // Address bits above ADDR_W must be zero.
          if ((byte_in >> (ADDR_W - 8)) != 8'h00) begin
            state_d = ST_ERR;
          end else begin
            adr_h_d = byte_in;
            state_d = ST_HDR_AL;
          end
        end
      end
      ST_HDR_AL: begin
        if (byte_valid) begin
          addr_d  = ADDR_W'({adr_h_q, byte_in});
          state_d = ST_HDR_CH;
        end
      end
      ST_HDR_CH: begin
        if (byte_valid) begin
          cnt_h_d = byte_in;
          state_d = ST_HDR_CL;
        end
      end
      ST_HDR_CL: begin
        if (byte_valid) begin
          if (count == 16'd0) begin
            state_d = ST_TAIL;
          end else if ({1'b0, count} > MAX_CNT) begin
            state_d = ST_ERR;
          end else begin
            rem_d   = count[ADDR_W:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          if (word_valid) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W + 1)'(1)) state_d = ST_TAIL;
        else                           state_d = ST_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (byte_valid) begin
          state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`else
      ST_FIN: state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      adr_h_q <= '0;
      cnt_h_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      adr_h_q <= adr_h_d;
      cnt_h_q <= cnt_h_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign w_enable = (state_q == ST_WRITE);
  assign w_adrs   = addr_q;
  assign busy     = !idle_like;
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign cpu_en   = AUTO_RUN && done;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] w_instruction;
  logic        w_enable;
  logic [10:0] w_adrs;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  bit gap   = 1'b0;

  logic [10:0] wa[$];
  logic [31:0] wd[$];
  int          run_len = 0;
  int          max_run = 0;

  prog_loader #(
    .ADDR_W   (11),
    .DATA_W   (32),
    .AUTO_RUN (1'b1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .w_instruction (w_instruction),
    .w_enable      (w_enable),
    .w_adrs        (w_adrs),
    .cpu_en        (cpu_en),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Write log and strobe-width tracking.
  always @(posedge clk) begin
    if (w_enable) begin
      wa.push_back(w_adrs);
      wd.push_back(w_instruction);
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    max_run = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) check("byte_ready timeout", byte_ready, 1);
    tick();
    if (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'hxx;
      tick();
    end
  endtask

  task automatic end_stream();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic send_tail(input logic [7:0] csum);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum);
`else
    if (csum === 8'hxx) tick();
`endif
  endtask

  task automatic load_basic(input string tag);
    clear_log();
    pulse_start();
    check({tag, " busy after start"}, busy, 1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    if (!gap) begin
      // Strobe in the cycle right after the 4th byte's transfer.
      check({tag, " w_enable latency"}, w_enable, 1);
      check({tag, " ready low in WRITE"}, byte_ready, 0);
    end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_tail(8'hEF);
    end_stream();
    wait_idle({tag, " finish"});
    check({tag, " nwrites"}, wa.size(), 2);
    if (wa.size() == 2) begin
      check({tag, " adrs0"}, wa[0], 1);
      check({tag, " data0"}, wd[0], 32'hE000_0007);
      check({tag, " adrs1"}, wa[1], 2);
      check({tag, " data1"}, wd[1], 32'h1234_5678);
    end
    check({tag, " strobe width"}, max_run, 1);
    check({tag, " done"}, done, 1);
    check({tag, " cpu_en"}, cpu_en, 1);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check("reset flags", {byte_ready, w_enable, cpu_en, busy, done, err}, 0);
    check("reset w_adrs", w_adrs, 0);
    check("reset w_instruction", w_instruction, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Basic two-word load, back-to-back bytes.
    load_basic("basic");

    // Address wrap 2047 -> 0.
    clear_log();
    pulse_start();
    check("wrap cleared done", done, 0);
    check("wrap cleared cpu_en", cpu_en, 0);
    send_byte(8'h07); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_tail(8'h88);
    end_stream();
    wait_idle("wrap finish");
    check("wrap nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      check("wrap adrs0", wa[0], 11'd2047);
      check("wrap data0", wd[0], 32'h1122_3344);
      check("wrap adrs1", wa[1], 0);
      check("wrap data1", wd[1], 32'h5566_7788);
    end
    check("wrap done", done, 1);

    // Illegal high address byte.
    clear_log();
    pulse_start();
    send_byte(8'h08);
    end_stream();
    check("badaddr err", err, 1);
    check("badaddr busy", busy, 0);
    check("badaddr cpu_en", cpu_en, 0);
    check("badaddr ready", byte_ready, 0);
    tick(); tick();
    check("badaddr err sticky", err, 1);
    check("badaddr nwrites", wa.size(), 0);

    // New start clears err; count 0 completes with no writes.
    pulse_start();
    check("restart clears err", err, 0);
    check("restart busy", busy, 1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_tail(8'h00);
    end_stream();
    wait_idle("cnt0 finish");
    check("cnt0 nwrites", wa.size(), 0);
    check("cnt0 done", done, 1);
    check("cnt0 err", err, 0);

    // Count 2049 exceeds memory size.
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08); send_byte(8'h01);
    end_stream();
    check("bigcnt err", err, 1);
    check("bigcnt cpu_en", cpu_en, 0);
    check("bigcnt nwrites", wa.size(), 0);

    // Same load with byte_valid low every other cycle.
    gap = 1'b1;
    load_basic("gapped");
    gap = 1'b0;

    // start while busy is ignored.
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h05);
    end_stream();
    pulse_start();
    check("start ignored busy", busy, 1);
    check("start ignored ready", byte_ready, 1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    end_stream();
    tick(); tick();
    check("stall keeps busy", busy, 1);

    // Asynchronous reset mid-load with a partial word held.
    #3;
    resetn = 1'b0;
    #1;
    check("async reset flags", {byte_ready, w_enable, cpu_en, busy, done, err}, 0);
    check("async reset w_adrs", w_adrs, 0);
    check("async reset w_instruction", w_instruction, 0);
    check("async reset nwrites", wa.size(), 0);
    tick();
    resetn = 1'b1;
    tick();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum.
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h08);
    end_stream();
    wait_idle("csum ok finish");
    check("csum ok done", done, 1);
    check("csum ok cpu_en", cpu_en, 1);
    // Bad checksum: write still issued, load flagged.
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    end_stream();
    wait_idle("csum bad finish");
    check("csum bad err", err, 1);
    check("csum bad cpu_en", cpu_en, 0);
    check("csum bad nwrites", wa.size(), 1);
    if (wa.size() == 1) check("csum bad adrs", wa[0], 11'h010);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
